soc_trace_event_decoder: RTL and testbench
==========================================

// Module: soc_trace_event_decoder
// PURPOSE
//  Consumes the per-core retired-instruction trace (peripheral_dbg_soc_mmsp430_trace_exec fields) of one compute tile core.
//  Shadows r3 and decodes marker instructions (EXIT/PUTC/REPORT) into a buffered event stream.
//  Latches a sticky termination flag with exit code and aggregates cross-core termination.
//  Sits between u_ct.trace and the simulation-side stdout/trace writers; synthesizable so it can also feed a debug-side sink.
// PARAMETERS
//  XLEN        32            trace data/pc width
//  INSN_W      32            trace instruction width
//  FIFO_DEPTH  4             event FIFO entries; power of 2, >=2
//  NOP_EXIT    32'h1501_0001 marker: terminate, exit code = r3
//  NOP_REPORT  32'h1501_0002 marker: report r3 as a value
//  NOP_PUTC    32'h1501_0004 marker: print char r3[7:0]
//  TERM_NUM    8             number of cores in termination cross (>=1)
// PORTS
//  clk         in   1         system clock
//  rst         in   1         synchronous, active-high reset
//  tr_valid    in   1         trace entry retired this cycle
//  tr_pc       in   XLEN      retired pc
//  tr_insn     in   INSN_W    retired instruction word
//  tr_wben     in   1         register writeback enable
//  tr_wbreg    in   5         writeback register index
//  tr_wbdata   in   XLEN      writeback data
//  evt_valid   out  1         event available at FIFO head
//  evt_ready   in   1         sink accepts head event
//  evt_type    out  2         evt_type_t (PUTC/REPORT/EXIT)
//  evt_data    out  XLEN      r3 value at marker (PUTC: zero-extended [7:0])
//  evt_pc      out  XLEN      pc of marker instruction
//  r3          out  XLEN      current r3 shadow
//  terminated  out  1         sticky: EXIT marker retired
//  exit_code   out  XLEN      r3 value at EXIT
//  term_all    in   TERM_NUM  terminated flags of all cores (incl. own)
//  all_done    out  1         terminated && &term_all, registered
//  drop_cnt    out  16        events lost to full FIFO, saturating
// BEHAVIOUR
//  - Reset: evt_valid=0, r3=0, terminated=0, exit_code=0, all_done=0, drop_cnt=0, FIFO empty; evt_type/data/pc=0.
//  - r3 shadow: tr_valid&&tr_wben&&tr_wbreg==3 -> r3<=tr_wbdata next cycle.
//  - Decode on tr_valid&&!terminated; operand = bypassed r3 (same-entry write wins over stored r3).
//  - insn==NOP_PUTC -> push {PUTC,{24'b0,op[7:0]},pc}; NOP_REPORT -> push {REPORT,op,pc};
//    NOP_EXIT -> push {EXIT,op,pc}, terminated<=1, exit_code<=op. Any other insn: no event.
//  - Latency: marker at cycle N -> evt_valid high at N+1 if FIFO was empty; fall-through not used.
//  - Handshake: pop when evt_valid&&evt_ready; head stable while evt_valid&&!evt_ready.
//  - Simultaneous push+pop on full FIFO: push accepted (pop frees slot same cycle); push+pop on empty: event appears next cycle.
//  - Full and no pop: event dropped, drop_cnt+1 saturating at 16'hFFFF; EXIT still sets terminated/exit_code even when dropped.
//  - After terminated: markers ignored, r3 shadow keeps tracking, FIFO drains normally.
//  - all_done <= terminated && (&term_all); deasserts only on rst.
//  - rst mid-operation: FIFO flushed, pending events lost, all state to reset values next edge.
//  - Pointers log2(FIFO_DEPTH)+1 bits; wrap naturally; full = MSB differ, rest equal.
// STRUCTURE
//  - Package soc_trace_event_pkg: typedef enum logic[1:0] evt_type_t {EVT_PUTC=0,EVT_REPORT=1,EVT_EXIT=2};
//    typedef struct packed trace_event_t {evt_type_t t; logic[XLEN-1:0] data, pc;}; default NOP_* constants.
//  - Sub-module soc_trace_event_fifo: synchronous FIFO of trace_event_t, push/pop/full/empty.
//  - Top: r3 shadow + bypass, marker compare, drop counter, termination registers.
// TESTING
//  1. rst 3 cycles -> all outputs 0; then wb r3=0x41, PUTC @pc 0x100 -> evt {PUTC,0x41,0x100} one cycle later.
//  2. Same-entry wben r3=0x5A with insn=NOP_REPORT -> evt_data=0x5A (bypass), r3 output 0x5A next cycle.
//  3. evt_ready=0, 6 PUTCs (DEPTH 4) -> 4 held in order, drop_cnt=2; release ready -> 4 pops, order preserved.
//  4. FIFO full, EXIT with r3=7 -> dropped, drop_cnt+1, terminated=1, exit_code=7; later PUTC -> no event.
//  5. terminated=1, term_all=8'hFE -> all_done=0; term_all=8'hFF -> all_done=1 next cycle.
//  6. rst asserted with 3 queued events -> evt_valid=0, drop_cnt=0, terminated=0 on next edge.

Source files
------------

// File: rtl/soc_trace_event_decoder_pkg.sv
// ---------------------------------------------------------------------------
// soc_trace_event_pkg
// Shared types and constants for the trace event decoder slice.
//   XLEN / INSN_W   : trace data and instruction widths
//   evt_type_t      : event kind carried on the event stream
//   trace_event_t   : one buffered event {type, r3 value, marker pc}
//   NOP_*_DFLT      : default marker instruction encodings
// ---------------------------------------------------------------------------
package soc_trace_event_pkg;

    localparam int XLEN   = 32;
    localparam int INSN_W = 32;

    localparam logic [INSN_W-1:0] NOP_EXIT_DFLT   = 32'h1501_0001;
    localparam logic [INSN_W-1:0] NOP_REPORT_DFLT = 32'h1501_0002;
    localparam logic [INSN_W-1:0] NOP_PUTC_DFLT   = 32'h1501_0004;

    typedef enum logic [1:0] {
        EVT_PUTC   = 2'd0,
        EVT_REPORT = 2'd1,
        EVT_EXIT   = 2'd2
    } evt_type_t;

    typedef struct packed {
        evt_type_t         t;
        logic [XLEN-1:0]   data;
        logic [XLEN-1:0]   pc;
    } trace_event_t;

endpackage

// File: rtl/soc_trace_event_decoder_if.sv
// ---------------------------------------------------------------------------
// soc_trace_event_decoder_if
// Bundles the retired-instruction trace bus and the outgoing event stream.
//   slave  : decoder side  (consumes trace, produces events)
//   master : environment   (drives trace, sinks events)
// ---------------------------------------------------------------------------
interface soc_trace_event_decoder_if;
    import soc_trace_event_pkg::*;

    // retired-instruction trace
    logic              tr_valid;
    logic [XLEN-1:0]   tr_pc;
    logic [INSN_W-1:0] tr_insn;
    logic              tr_wben;
    logic [4:0]        tr_wbreg;
    logic [XLEN-1:0]   tr_wbdata;

    // event stream
    logic              evt_valid;
    logic              evt_ready;
    evt_type_t         evt_type;
    logic [XLEN-1:0]   evt_data;
    logic [XLEN-1:0]   evt_pc;

    modport slave (
        input  tr_valid, tr_pc, tr_insn, tr_wben, tr_wbreg, tr_wbdata,
        input  evt_ready,
        output evt_valid, evt_type, evt_data, evt_pc
    );

    modport master (
        output tr_valid, tr_pc, tr_insn, tr_wben, tr_wbreg, tr_wbdata,
        output evt_ready,
        input  evt_valid, evt_type, evt_data, evt_pc
    );

endinterface

// File: rtl/soc_trace_event_decoder_fifo.sv
// ---------------------------------------------------------------------------
// soc_trace_event_fifo
// Synchronous FIFO of trace_event_t.
//   clk, rst  : clock, synchronous active-high reset (flushes pointers)
//   push_i    : write din_i (accepted when not full, or when popping)
//   din_i     : event to store
//   pop_i     : remove head (ignored when empty)
//   dout_o    : head event, all-zero while empty
//   full_o    : no free slot
//   empty_o   : no stored event
// ---------------------------------------------------------------------------
module soc_trace_event_fifo
    import soc_trace_event_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push_i,
    input  trace_event_t din_i,
    input  logic         pop_i,
    output trace_event_t dout_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int AW = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty when indices match.
    logic [AW:0]  wr_ptr_q, wr_ptr_d;
    logic [AW:0]  rd_ptr_q, rd_ptr_d;
    trace_event_t mem_q [DEPTH];

    logic push_ok;
    logic pop_ok;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop in the same cycle frees the slot the push lands in.
    assign push_ok = push_i && (!full_o || pop_i);
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + 1'b1;
        if (pop_ok)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: the head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din_i;
    end

    assign dout_o = empty_o ? '0 : mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/soc_trace_event_decoder.sv
// ---------------------------------------------------------------------------
// soc_trace_event_decoder
// Shadows r3 from one core's retired-instruction trace, decodes marker NOPs
// (EXIT/REPORT/PUTC) into a buffered event stream, and latches termination.
//   clk, rst       : clock, synchronous active-high reset
//   bus (slave)    : trace inputs tr_*, event stream evt_valid/ready/type/data/pc
//   r3_o           : current r3 shadow
//   terminated_o   : sticky, EXIT marker retired
//   exit_code_o    : r3 value at EXIT
//   term_all_i     : terminated flags of all cores (including this one)
//   all_done_o     : sticky, this core terminated and all cores terminated
//   drop_cnt_o     : saturating count of events lost to a full FIFO
// ---------------------------------------------------------------------------
module soc_trace_event_decoder
    import soc_trace_event_pkg::*;
#(
    parameter int                FIFO_DEPTH = 4,
    parameter logic [INSN_W-1:0] NOP_EXIT   = NOP_EXIT_DFLT,
    parameter logic [INSN_W-1:0] NOP_REPORT = NOP_REPORT_DFLT,
    parameter logic [INSN_W-1:0] NOP_PUTC   = NOP_PUTC_DFLT,
    parameter int                TERM_NUM   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    soc_trace_event_decoder_if.slave bus,
    output logic [XLEN-1:0]        r3_o,
    output logic                   terminated_o,
    output logic [XLEN-1:0]        exit_code_o,
    input  logic [TERM_NUM-1:0]    term_all_i,
    output logic                   all_done_o,
    output logic [15:0]            drop_cnt_o
);

    logic [XLEN-1:0] r3_q, r3_d;
    logic            terminated_q, terminated_d;
    logic [XLEN-1:0] exit_code_q, exit_code_d;
    logic            all_done_q, all_done_d;
    logic [15:0]     drop_cnt_q, drop_cnt_d;

    logic            r3_wr;
    logic [XLEN-1:0] operand;
    logic            decode_en;
    logic            push;
    trace_event_t    push_evt;
    trace_event_t    head_evt;
    logic            fifo_full;
    logic            fifo_empty;
    logic            pop;
    logic            drop;

    assign r3_wr = bus.tr_valid && bus.tr_wben && (bus.tr_wbreg == 5'd3);

    // The marker sees the r3 value as of its own retirement, so a write in
    // the same trace entry takes priority over the stored shadow.
    assign operand   = r3_wr ? bus.tr_wbdata : r3_q;
    assign decode_en = bus.tr_valid && !terminated_q;

    always_comb begin
        push          = 1'b0;
        push_evt      = '0;
        push_evt.pc   = bus.tr_pc;
        push_evt.data = operand;
        if (decode_en) begin
            if (bus.tr_insn == NOP_PUTC) begin
                push          = 1'b1;
                push_evt.t    = EVT_PUTC;
                push_evt.data = {{(XLEN-8){1'b0}}, operand[7:0]};
            end else if (bus.tr_insn == NOP_REPORT) begin
                push       = 1'b1;
                push_evt.t = EVT_REPORT;
            end else if (bus.tr_insn == NOP_EXIT) begin
                push       = 1'b1;
                push_evt.t = EVT_EXIT;
            end
        end
    end

    soc_trace_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_evt),
        .pop_i   (pop),
        .dout_o  (head_evt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign pop  = !fifo_empty && bus.evt_ready;
    assign drop = push && fifo_full && !pop;

    always_comb begin
        r3_d         = r3_q;
        terminated_d = terminated_q;
        exit_code_d  = exit_code_q;
        all_done_d   = all_done_q;
        drop_cnt_d   = drop_cnt_q;

        if (r3_wr) r3_d = bus.tr_wbdata;

        // EXIT terminates even when its event cannot be buffered.
        if (decode_en && (bus.tr_insn == NOP_EXIT)) begin
            terminated_d = 1'b1;
            exit_code_d  = operand;
        end

        if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_d = drop_cnt_q + 16'd1;

        if (terminated_q && (&term_all_i)) all_done_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r3_q         <= '0;
            terminated_q <= 1'b0;
            exit_code_q  <= '0;
            all_done_q   <= 1'b0;
            drop_cnt_q   <= '0;
        end else begin
            r3_q         <= r3_d;
            terminated_q <= terminated_d;
            exit_code_q  <= exit_code_d;
            all_done_q   <= all_done_d;
            drop_cnt_q   <= drop_cnt_d;
        end
    end

    assign bus.evt_valid = !fifo_empty;
    assign bus.evt_type  = head_evt.t;
    assign bus.evt_data  = head_evt.data;
    assign bus.evt_pc    = head_evt.pc;

    assign r3_o         = r3_q;
    assign terminated_o = terminated_q;
    assign exit_code_o  = exit_code_q;
    assign all_done_o   = all_done_q;
    assign drop_cnt_o   = drop_cnt_q;

endmodule

// File: tb/tb_soc_trace_event_decoder.sv
// ---------------------------------------------------------------------------
// tb_soc_trace_event_decoder
// Drives directed and random trace entries into soc_trace_event_decoder and
// compares every cycle against a transaction-level model built on a queue.
// ---------------------------------------------------------------------------
module tb_soc_trace_event_decoder;

    localparam int          DEPTH  = 4;
    localparam logic [31:0] I_EXIT = 32'h1501_0001;
    localparam logic [31:0] I_REP  = 32'h1501_0002;
    localparam logic [31:0] I_PUTC = 32'h1501_0004;

    typedef struct {
        logic [1:0]  t;
        logic [31:0] data;
        logic [31:0] pc;
    } ev_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  term_all;
    logic [31:0] r3;
    logic        terminated;
    logic [31:0] exit_code;
    logic        all_done;
    logic [15:0] drop_cnt;

    int n_checks = 0;
    int n_pass   = 0;

    // reference model state
    ev_t         mq[$];
    logic [31:0] m_r3;
    logic        m_term;
    logic [31:0] m_exit;
    logic        m_done;
    logic [15:0] m_drop;

    soc_trace_event_decoder_if bus ();

    soc_trace_event_decoder dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bus),
        .r3_o         (r3),
        .terminated_o (terminated),
        .exit_code_o  (exit_code),
        .term_all_i   (term_all),
        .all_done_o   (all_done),
        .drop_cnt_o   (drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s got=%08h expected=%08h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic model_reset();
        mq.delete();
        m_r3   = '0;
        m_term = 1'b0;
        m_exit = '0;
        m_done = 1'b0;
        m_drop = '0;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".evt_valid"}, 32'(bus.evt_valid), 32'(mq.size() > 0));
        if (mq.size() > 0) begin
            check({tag, ".evt_type"}, 32'(bus.evt_type), 32'(mq[0].t));
            check({tag, ".evt_data"}, bus.evt_data, mq[0].data);
            check({tag, ".evt_pc"},   bus.evt_pc,   mq[0].pc);
        end
        check({tag, ".r3"},         r3,                 m_r3);
        check({tag, ".terminated"}, 32'(terminated),    32'(m_term));
        check({tag, ".exit_code"},  exit_code,          m_exit);
        check({tag, ".all_done"},   32'(all_done),      32'(m_done));
        check({tag, ".drop_cnt"},   32'(drop_cnt),      32'(m_drop));
    endtask

    // One clock: drive inputs, advance the model, check after the edge.
    task automatic step(input string tag, input logic v, input logic [31:0] pc,
                        input logic [31:0] insn, input logic wben, input logic [4:0] wbreg,
                        input logic [31:0] wbdata, input logic rdy, input logic [7:0] ta);
        logic [31:0] op;
        logic        pop;
        logic        is_mk;
        ev_t         e;
        ev_t         popped;
        bus.tr_valid  = v;
        bus.tr_pc     = pc;
        bus.tr_insn   = insn;
        bus.tr_wben   = wben;
        bus.tr_wbreg  = wbreg;
        bus.tr_wbdata = wbdata;
        bus.evt_ready = rdy;
        term_all      = ta;

        if (rst) begin
            model_reset();
        end else begin
            op    = (v && wben && wbreg == 5'd3) ? wbdata : m_r3;
            pop   = (mq.size() > 0) && rdy;
            is_mk = v && !m_term && (insn == I_PUTC || insn == I_REP || insn == I_EXIT);
            if (m_term && ta == 8'hFF) m_done = 1'b1;
            if (pop) begin
                popped = mq.pop_front();
                $display("pop  type=%0d data=%08h pc=%08h", popped.t, popped.data, popped.pc);
            end
            if (is_mk) begin
                e.pc = pc;
                if (insn == I_PUTC) begin
                    e.t = 2'd0; e.data = op & 32'h0000_00FF;
                end else if (insn == I_REP) begin
                    e.t = 2'd1; e.data = op;
                end else begin
                    e.t = 2'd2; e.data = op;
                    m_term = 1'b1;
                    m_exit = op;
                end
                if (mq.size() < DEPTH) mq.push_back(e);
                else if (m_drop != 16'hFFFF) m_drop = m_drop + 16'd1;
            end
            if (v && wben && wbreg == 5'd3) m_r3 = wbdata;
        end

        @(posedge clk);
        @(negedge clk);
        check_all(tag);
    endtask

    task automatic idle(input string tag, input logic rdy);
        step(tag, 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, rdy, 8'h00);
    endtask

    initial begin
        model_reset();

        // 1: reset, then r3 write and a PUTC
        rst = 1'b1;
        for (int i = 0; i < 3; i++) idle("rst", 1'b0);
        check("rst.evt_type", 32'(bus.evt_type), 32'd0);
        check("rst.evt_data", bus.evt_data, 32'd0);
        check("rst.evt_pc",   bus.evt_pc,   32'd0);
        rst = 1'b0;
        step("t1.wb", 1'b1, 32'h0FC, 32'h0000_0013, 1'b1, 5'd3, 32'h41, 1'b0, 8'h00);
        step("t1.putc", 1'b1, 32'h100, I_PUTC, 1'b0, 5'd0, 32'h0, 1'b0, 8'h00);
        check("t1.valid", 32'(bus.evt_valid), 32'd1);
        check("t1.data",  bus.evt_data, 32'h41);
        check("t1.pc",    bus.evt_pc,   32'h100);
        idle("t1.pop", 1'b1);

        // 2: same-entry write is bypassed into the REPORT operand
        step("t2.rep", 1'b1, 32'h104, I_REP, 1'b1, 5'd3, 32'h5A, 1'b0, 8'h00);
        check("t2.data", bus.evt_data, 32'h5A);
        check("t2.r3",   r3, 32'h5A);
        idle("t2.pop", 1'b1);

        // 3: six PUTCs into a stalled 4-deep FIFO, then drain
        for (int i = 0; i < 6; i++)
            step("t3.putc", 1'b1, 32'h200 + 32'(4 * i), I_PUTC, 1'b1, 5'd3,
                 32'h161 + 32'(i), 1'b0, 8'h00);
        check("t3.drop", 32'(drop_cnt), 32'd2);
        for (int i = 0; i < 5; i++) idle("t3.drain", 1'b1);
        check("t3.empty", 32'(bus.evt_valid), 32'd0);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            int unsigned sel;
            logic [31:0] insn;
            sel = $urandom_range(0, 99);
            if (sel < 20)      insn = I_PUTC;
            else if (sel < 35) insn = I_REP;
            else if (sel < 37) insn = I_EXIT;
            else               insn = $urandom;
            step("rnd", 1'($urandom_range(0, 3) != 0), $urandom, insn, 1'($urandom),
                 5'($urandom_range(0, 7)), $urandom, 1'($urandom),
                 ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom));
        end

        // 4: EXIT into a full FIFO
        rst = 1'b1;
        idle("t4.rst", 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++)
            step("t4.fill", 1'b1, 32'h300 + 32'(4 * i), I_PUTC, 1'b1, 5'd3,
                 32'h30 + 32'(i), 1'b0, 8'h00);
        step("t4.wb", 1'b1, 32'h310, 32'h0000_0013, 1'b1, 5'd3, 32'h7, 1'b0, 8'h00);
        step("t4.exit", 1'b1, 32'h314, I_EXIT, 1'b0, 5'd0, 32'h0, 1'b0, 8'h00);
        check("t4.drop",       32'(drop_cnt),   32'd1);
        check("t4.terminated", 32'(terminated), 32'd1);
        check("t4.exit_code",  exit_code,       32'd7);
        step("t4.putc_after", 1'b1, 32'h318, I_PUTC, 1'b0, 5'd0, 32'h0, 1'b0, 8'h00);
        check("t4.drop_after", 32'(drop_cnt), 32'd1);
        for (int i = 0; i < 5; i++) idle("t4.drain", 1'b1);
        check("t4.drained", 32'(bus.evt_valid), 32'd0);

        // 5: cross-core termination
        step("t5.fe", 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 8'hFE);
        check("t5.not_done", 32'(all_done), 32'd0);
        step("t5.ff", 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 8'hFF);
        check("t5.done", 32'(all_done), 32'd1);
        step("t5.sticky", 1'b0, 32'h0, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1, 8'h00);

        // 6: reset with queued events
        rst = 1'b1;
        idle("t6.rst", 1'b0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++)
            step("t6.q", 1'b1, 32'h400 + 32'(4 * i), I_REP, 1'b0, 5'd0, 32'h0, 1'b0, 8'h00);
        check("t6.queued", 32'(bus.evt_valid), 32'd1);
        rst = 1'b1;
        idle("t6.rst2", 1'b0);
        check("t6.valid",      32'(bus.evt_valid), 32'd0);
        check("t6.drop",       32'(drop_cnt),      32'd0);
        check("t6.terminated", 32'(terminated),    32'd0);
        rst = 1'b0;
        idle("t6.after", 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
